// File: rtl/ctrl_xfer_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// ctrl_xfer_seq: CALL/RET/INT stack micro-op sequencer with one-cycle PC redirect
// Revision: 1.0
//----------------------------------------------------------------------------
module ctrl_xfer_seq #(
  parameter int                DATA_W    = 16,
  parameter int                PC_W      = 32,
  parameter logic [DATA_W-1:0] PUSH_BASE = 16'h6008,
  parameter logic [DATA_W-1:0] POP_BASE  = 16'h6010,
  parameter logic [DATA_W-1:0] PUSHF_OP  = 16'h6018,
  parameter logic [PC_W-1:0]   INT_VEC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call,
  input  logic              ret,
  input  logic              intr,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] pop_data,
  input  logic              pop_valid,
  output logic [DATA_W-1:0] uop,
  output logic              stall,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              busy
);

  localparam int                 c_pc_words = PC_W / DATA_W;
  localparam int                 c_cnt_w    = $clog2(c_pc_words + 2);
  localparam logic [c_cnt_w-1:0] c_words    = c_cnt_w'(c_pc_words);
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(c_pc_words - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_POP      = 3'd2,
    ST_COLLECT  = 3'd3,
    ST_REDIRECT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_cnt_w-1:0]  rcv_q, rcv_d;
  logic                int_q, int_d;
  logic [PC_W-1:0]     dest_q, dest_d;
  logic [PC_W-1:0]     buf_q, buf_d;
  logic [DATA_W-1:0]   uop_q, uop_d;
  logic                stall_q, stall_d;
  logic                redirect_q, redirect_d;
  logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
  logic [c_cnt_w-1:0]  w_cnt_dec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rcv_q         <= '0;
      int_q         <= 1'b0;
      dest_q        <= '0;
      buf_q         <= '0;
      uop_q         <= '0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rcv_q         <= rcv_d;
      int_q         <= int_d;
      dest_q        <= dest_d;
      buf_q         <= buf_d;
      uop_q         <= uop_d;
      stall_q       <= stall_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rcv_d         = rcv_q;
    int_d         = int_q;
    dest_d        = dest_q;
    buf_d         = buf_q;
    uop_d         = '0;
    stall_d       = 1'b1;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    w_cnt_dec     = cnt_q - 1'b1;

    // Returned words arrive high-first, so shifting left reassembles the PC.
    if ((state_q == ST_POP || state_q == ST_COLLECT) && pop_valid) begin
      buf_d = (buf_q << DATA_W) | PC_W'(pop_data);
      if (rcv_q != c_words) rcv_d = rcv_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        stall_d = 1'b0;
        if (intr || call) begin
          int_d   = intr;
          dest_d  = intr ? INT_VEC : PC_W'(target);
          cnt_d   = c_cnt_w'(1);
          uop_d   = PUSH_BASE;
          stall_d = 1'b1;
          state_d = ST_PUSH;
        end else if (ret) begin
          int_d   = 1'b0;
          cnt_d   = c_last;
          rcv_d   = '0;
          uop_d   = POP_BASE + DATA_W'(c_last);
          stall_d = 1'b1;
          state_d = ST_POP;
        end
      end
      // cnt_q is the index of the next word to push; c_words marks the flags slot.
      ST_PUSH: begin
        if (cnt_q < c_words) begin
          uop_d = PUSH_BASE + DATA_W'(cnt_q);
          cnt_d = cnt_q + 1'b1;
        end else if (int_q && cnt_q == c_words) begin
          uop_d = PUSHF_OP;
          cnt_d = cnt_q + 1'b1;
        end else begin
          redirect_d    = 1'b1;
          redirect_pc_d = dest_q;
          state_d       = ST_REDIRECT;
        end
      end
      // cnt_q is the index of the pop currently on uop.
      ST_POP: begin
        if (cnt_q != '0) begin
          uop_d = POP_BASE + DATA_W'(w_cnt_dec);
          cnt_d = w_cnt_dec;
        end else if (rcv_d == c_words) begin
          redirect_d    = 1'b1;
          redirect_pc_d = buf_d;
          state_d       = ST_REDIRECT;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (rcv_d == c_words) begin
          redirect_d    = 1'b1;
          redirect_pc_d = buf_d;
          state_d       = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        stall_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        stall_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign uop         = uop_q;
  assign stall       = stall_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_xfer_seq.sv
`default_nettype none
// Scoreboard bench for ctrl_xfer_seq: a 32-bit-PC and a 48-bit-PC instance share
// the stimulus, selected by sel; expected micro-ops/redirects/stall runs are queued.
module tb_ctrl_xfer_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        call, ret, intr, pop_valid, sel, mon_en;
  logic [15:0] target, pop_data;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] uop0, uop1;
  logic        stall0, stall1, redirect0, redirect1, busy0, busy1;
  logic [31:0] rpc0;
  logic [47:0] rpc1;

  wire call0 = call & ~sel;
  wire ret0  = ret & ~sel;
  wire intr0 = intr & ~sel;
  wire pv0   = pop_valid & ~sel;
  wire call1 = call & sel;
  wire ret1  = ret & sel;
  wire intr1 = intr & sel;
  wire pv1   = pop_valid & sel;

  wire [15:0] m_uop      = sel ? uop1 : uop0;
  wire        m_stall    = sel ? stall1 : stall0;
  wire        m_redirect = sel ? redirect1 : redirect0;
  wire        m_busy     = sel ? busy1 : busy0;
  wire [47:0] m_rpc      = sel ? rpc1 : {16'h0, rpc0};

  ctrl_xfer_seq u_dut0 (
    .clk(clk), .reset(reset), .call(call0), .ret(ret0), .intr(intr0),
    .target(target), .pop_data(pop_data), .pop_valid(pv0),
    .uop(uop0), .stall(stall0), .redirect(redirect0), .redirect_pc(rpc0), .busy(busy0)
  );

  ctrl_xfer_seq #(.DATA_W(16), .PC_W(48), .INT_VEC(48'h0000_0000_0C00)) u_dut1 (
    .clk(clk), .reset(reset), .call(call1), .ret(ret1), .intr(intr1),
    .target(target), .pop_data(pop_data), .pop_valid(pv1),
    .uop(uop1), .stall(stall1), .redirect(redirect1), .redirect_pc(rpc1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 = micro-op, 1 = redirect, 2 = stall run
    int          t;
    logic [47:0] val;
  } ev_t;

  ev_t q_ev[$];
  ev_t q_st[$];

  function automatic string kname(input int k);
    return (k == 0) ? "uop" : (k == 1) ? "redirect" : "stall";
  endfunction

  task automatic push_ev(input int kind, input int t, input logic [47:0] val);
    ev_t e;
    e.kind = kind; e.t = t; e.val = val;
    if (kind == 2) q_st.push_back(e);
    else q_ev.push_back(e);
  endtask

  task automatic chk_eq(input string name, input logic [47:0] got, input logic [47:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Event comparison: for stall runs val is the run length and t the first stall cycle.
  task automatic chk_ev(input int kind, input int t, input logic [47:0] val);
    ev_t e;
    n_cmp++;
    if (kind == 2 ? q_st.size() == 0 : q_ev.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got %h at cycle %0d, none required", kname(kind), val, t);
    end else begin
      e = (kind == 2) ? q_st.pop_front() : q_ev.pop_front();
      if (e.kind != kind || e.t != t || e.val !== val) begin
        n_bad++;
        $display("FAIL %s: got %s %h at cycle %0d, required %s %h at cycle %0d",
                 kname(kind), kname(kind), val, t, kname(e.kind), e.val, e.t);
      end
    end
  endtask

  int st_len   = 0;
  int st_start = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_uop != 16'h0) chk_ev(0, cyc, {32'h0, m_uop});
      if (m_redirect)     chk_ev(1, cyc, m_rpc);
      if (m_stall) begin
        if (st_len == 0) st_start = cyc;
        st_len++;
      end else if (st_len != 0) begin
        chk_ev(2, st_start, 48'(st_len));
        st_len = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_uop"}, {32'h0, m_uop}, 48'h0);
    chk_eq({tag, "_stall"}, {47'h0, m_stall}, 48'h0);
    chk_eq({tag, "_redirect"}, {47'h0, m_redirect}, 48'h0);
    chk_eq({tag, "_redirect_pc"}, m_rpc, 48'h0);
    chk_eq({tag, "_busy"}, {47'h0, m_busy}, 48'h0);
  endtask

  int t0;

  initial begin
    reset = 1'b0; call = 0; ret = 0; intr = 0; pop_valid = 0; sel = 0; mon_en = 0;
    target = '0; pop_data = '0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1; mon_en = 1'b1;
    tick(2);

    // CALL with default parameters
    t0 = cyc; call = 1; target = 16'h00A5;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009);
    push_ev(1, t0+3, 48'h0000_0000_00A5); push_ev(2, t0+1, 48'd3);
    tick(1); call = 0; target = '0;
    tick(1); chk_eq("busy_in_call", {47'h0, m_busy}, 48'h1);
    wait_to(t0+4); chk_eq("busy_after_call", {47'h0, m_busy}, 48'h0);
    tick(2);

    // Reset during the second PUSH cycle abandons the CALL
    t0 = cyc; call = 1; target = 16'h0042;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009); push_ev(2, t0+1, 48'd2);
    tick(1); call = 0;
    wait_to(t0+2); reset = 1'b0;
    tick(1); chk_all_zero("midreset"); reset = 1'b1;
    tick(4);
    t0 = cyc; call = 1; target = 16'h0077;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009);
    push_ev(1, t0+3, 48'h77); push_ev(2, t0+1, 48'd3);
    tick(1); call = 0;
    tick(5);

    // RET with late data: arrivals 2 and 4 cycles after the last pop
    t0 = cyc; ret = 1;
    push_ev(0, t0+1, 48'h6011); push_ev(0, t0+2, 48'h6010);
    push_ev(1, t0+7, 48'h0000_0001_2345); push_ev(2, t0+1, 48'd7);
    tick(1); ret = 0;
    wait_to(t0+4); pop_valid = 1; pop_data = 16'h0001;
    tick(1); pop_valid = 0;
    wait_to(t0+6); pop_valid = 1; pop_data = 16'h2345;
    tick(1); pop_valid = 0; pop_data = '0;
    tick(3);

    // RET with both words during POP, second on the final POP cycle: minimum length
    t0 = cyc; ret = 1; pop_valid = 1; pop_data = 16'h0;
    push_ev(0, t0+1, 48'h6011); push_ev(0, t0+2, 48'h6010);
    push_ev(1, t0+3, 48'h0000_DEAD_BEEF); push_ev(2, t0+1, 48'd3);
    pop_valid = 0;
    tick(1); ret = 0; pop_valid = 1; pop_data = 16'hDEAD;
    tick(1); pop_data = 16'hBEEF;
    tick(1); pop_valid = 0; pop_data = '0;
    tick(4);

    // Simultaneous requests: INT wins, the others are dropped
    t0 = cyc; intr = 1; call = 1; ret = 1; target = 16'h1234;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009); push_ev(0, t0+3, 48'h6018);
    push_ev(1, t0+4, 48'h0); push_ev(2, t0+1, 48'd4);
    tick(1); intr = 0; call = 0; ret = 0; target = '0;
    tick(8);

    // CALL held high: second CALL one cycle after IDLE; pop_valid during PUSH ignored
    t0 = cyc; call = 1; target = 16'h0010;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009); push_ev(1, t0+3, 48'h10);
    push_ev(0, t0+5, 48'h6008); push_ev(0, t0+6, 48'h6009); push_ev(1, t0+7, 48'h10);
    push_ev(2, t0+1, 48'd3); push_ev(2, t0+5, 48'd3);
    tick(1); pop_valid = 1; pop_data = 16'hFFFF;
    tick(2); pop_valid = 0; pop_data = '0;
    wait_to(t0+5); call = 0; target = '0;
    tick(5);

    // 48-bit PC instance
    sel = 1;
    tick(2);
    t0 = cyc; call = 1; target = 16'h0ABC;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009); push_ev(0, t0+3, 48'h600A);
    push_ev(1, t0+4, 48'h0000_0000_0ABC); push_ev(2, t0+1, 48'd4);
    tick(1); call = 0; target = '0;
    tick(5);

    t0 = cyc; ret = 1;
    push_ev(0, t0+1, 48'h6012); push_ev(0, t0+2, 48'h6011); push_ev(0, t0+3, 48'h6010);
    push_ev(1, t0+6, 48'h1111_2222_3333); push_ev(2, t0+1, 48'd6);
    tick(1); ret = 0;
    wait_to(t0+2); pop_valid = 1; pop_data = 16'h1111;
    tick(1); pop_data = 16'h2222;
    tick(1); pop_valid = 0;
    wait_to(t0+5); pop_valid = 1; pop_data = 16'h3333;
    tick(1); pop_valid = 0; pop_data = '0;
    tick(4);

    t0 = cyc; intr = 1;
    push_ev(0, t0+1, 48'h6008); push_ev(0, t0+2, 48'h6009); push_ev(0, t0+3, 48'h600A);
    push_ev(0, t0+4, 48'h6018); push_ev(1, t0+5, 48'h0000_0000_0C00); push_ev(2, t0+1, 48'd5);
    tick(1); intr = 0;
    tick(8);

    chk_eq("pending_events", 48'(q_ev.size()), 48'h0);
    chk_eq("pending_stall_runs", 48'(q_st.size()), 48'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
